// File: rtl/conv_window_mac_pkg.sv
// Shared definitions for the convolution window MAC: data widths, tap count,
// and FSM state encoding.
package conv_window_mac_pkg;

  localparam int PIX_W  = 4;
  localparam int K_W    = 4;
  localparam int IMG_N  = 4;
  localparam int K_N    = 3;
  localparam int ACC_W  = 12;

  localparam int TAPS   = K_N * K_N;
  localparam int TAP_W  = 4;
  localparam int ADDR_W = 4;
  localparam int PROD_W = PIX_W + K_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } conv_state_e;

endpackage

// File: rtl/conv_window_mac_addr_gen.sv
// Combinational tap decoder: maps window origin and tap number to the image
// read address and the kernel coefficient index. Out-of-range taps (>= 9)
// decode to address 0 / coefficient 0 with tap_ok low.
module conv_addr_gen
  import conv_window_mac_pkg::*;
(
  input  logic              org_r,
  input  logic              org_c,
  input  logic [TAP_W-1:0]  tap,
  output logic              tap_ok,
  output logic [ADDR_W-1:0] pix_addr,
  output logic [TAP_W-1:0]  k_sel
);

  logic [TAP_W-1:0] kr;
  logic [TAP_W-1:0] kc;
  logic [TAP_W-1:0] row;
  logic [TAP_W-1:0] col;

  // Split tap into kernel row/col and offset by the window origin
  always_comb begin
    tap_ok   = (tap < TAP_W'(TAPS));
    kr       = tap / TAP_W'(K_N);
    kc       = tap % TAP_W'(K_N);
    row      = TAP_W'(org_r) + kr;
    col      = TAP_W'(org_c) + kc;
    pix_addr = '0;
    k_sel    = '0;
    if (tap_ok) begin
      pix_addr = ADDR_W'(row * TAP_W'(IMG_N) + col);
      k_sel    = kr * TAP_W'(K_N) + kc;
    end
  end

endmodule

// File: rtl/conv_window_mac.sv
// conv_window_mac: walks a 3x3 window of a 4x4 unsigned image and accumulates
// the signed product with a 3x3 signed kernel, one tap per cycle, then offers
// the sum over a valid/ready handshake.
// Optional build macro CONV_RELU_EN: clamp negative sums to zero on load.
module conv_window_mac
  import conv_window_mac_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             win_idx,
  input  logic                   start,
  output logic                   busy,
  output logic [ADDR_W-1:0]      pix_addr,
  input  logic [PIX_W-1:0]       pix_data,
  input  logic [K_N*K_N*K_W-1:0] kernel,
  output logic [ACC_W-1:0]       result,
  output logic                   result_valid,
  input  logic                   result_ready
);

  conv_state_e       state_q, state_d;
  logic              org_r_q, org_r_d;
  logic              org_c_q, org_c_d;
  logic [TAP_W-1:0]  tap_q, tap_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  result_q, result_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;

  logic              tap_ok;
  logic [ADDR_W-1:0] gen_addr;
  logic [TAP_W-1:0]  k_sel;

  logic signed [PIX_W:0]    pix_s;
  logic signed [K_W-1:0]    coef;
  logic signed [PROD_W-1:0] prod;
  logic [ACC_W-1:0]         prod_ext;
  logic [ACC_W-1:0]         acc_out;

  conv_addr_gen u_addr_gen (
    .org_r    (org_r_q),
    .org_c    (org_c_q),
    .tap      (tap_q),
    .tap_ok   (tap_ok),
    .pix_addr (gen_addr),
    .k_sel    (k_sel)
  );

  // Signed product of the current tap, sign-extended to accumulator width
  always_comb begin
    pix_s    = $signed({1'b0, pix_data});
    coef     = $signed(kernel[k_sel*K_W +: K_W]);
    prod     = pix_s * coef;
    prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  end

  // Value presented to result at the end of a window
  always_comb begin
`ifdef CONV_RELU_EN
    acc_out = acc_q[ACC_W-1] ? '0 : acc_q;
`else
    acc_out = acc_q;
`endif
  end

  // Next-state logic. The extra ACCUM cycle with tap == 9 loads the result
  // from the completed accumulator, giving the 10-edge start-to-valid latency.
  always_comb begin
    state_d  = state_q;
    org_r_d  = org_r_q;
    org_c_d  = org_c_q;
    tap_d    = tap_q;
    acc_d    = acc_q;
    result_d = result_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          org_r_d = win_idx[1];
          org_c_d = win_idx[0];
          acc_d   = '0;
          tap_d   = '0;
          busy_d  = 1'b1;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (tap_ok) begin
          acc_d = acc_q + prod_ext;
          tap_d = tap_q + 1'b1;
        end else begin
          result_d = acc_out;
          valid_d  = 1'b1;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (result_ready) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      org_r_q  <= 1'b0;
      org_c_q  <= 1'b0;
      tap_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      org_r_q  <= org_r_d;
      org_c_q  <= org_c_d;
      tap_q    <= tap_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign pix_addr     = (state_q == ACCUM && tap_ok) ? gen_addr : '0;
  assign busy         = busy_q;
  assign result       = result_q;
  assign result_valid = valid_q;

endmodule

// File: tb/tb_conv_window_mac.sv
// Directed testbench for conv_window_mac with hand-computed expected sums.
module tb_conv_window_mac;

  logic        clk;
  logic        reset;
  logic [1:0]  win_idx;
  logic        start;
  logic        busy;
  logic [3:0]  pix_addr;
  logic [3:0]  pix_data;
  logic [35:0] kernel;
  logic [11:0] result;
  logic        result_valid;
  logic        result_ready;

  logic [3:0]  img [16];

  int unsigned n_checks;
  int unsigned n_errors;

  localparam logic [35:0] K_ONES   = 36'h111111111;
  localparam logic [35:0] K_NEG    = 36'hFFFFFFFFF;
  localparam logic [35:0] K_CENTER = 36'h000010000;

  conv_window_mac dut (
    .clk          (clk),
    .reset        (reset),
    .win_idx      (win_idx),
    .start        (start),
    .busy         (busy),
    .pix_addr     (pix_addr),
    .pix_data     (pix_data),
    .kernel       (kernel),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign pix_data = img[pix_addr];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 16; i++) img[i] = 4'(i);
  endtask

  // Start one window, check latency, optional address walk, and result
  task automatic run_window(input string tag, input logic [1:0] idx,
                            input logic [11:0] exp_res, input bit chk_addr,
                            input logic [3:0] exp_addr [9]);
    int unsigned cnt;
    win_idx = idx;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    win_idx = ~idx;
    cnt = 0;
    while (!result_valid && cnt < 20) begin
      if (chk_addr && cnt < 9)
        check_eq($sformatf("%s_addr%0d", tag, cnt), 32'(pix_addr), 32'(exp_addr[cnt]));
      tick();
      cnt++;
    end
    check_eq({tag, "_latency"}, cnt, 32'd10);
    check_eq({tag, "_result"}, 32'(result), 32'(exp_res));
    check_eq({tag, "_busy"}, 32'(busy), 32'd1);
  endtask

  task automatic accept();
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check_eq("accept_valid", 32'(result_valid), 32'd0);
    check_eq("accept_busy", 32'(busy), 32'd0);
  endtask

  logic [3:0] addr_w0 [9];
  logic [3:0] addr_w3 [9];
  logic [3:0] no_addr [9];
  logic [11:0] exp_neg;

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b0;
    start = 1'b0;
    win_idx = 2'd0;
    result_ready = 1'b0;
    kernel = K_ONES;
    load_ramp();
    addr_w0 = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10};
    addr_w3 = '{4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd13, 4'd14, 4'd15};
    no_addr = '{default: 4'd0};

    tick();
    tick();
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_valid", 32'(result_valid), 32'd0);
    check_eq("rst_result", 32'(result), 32'd0);
    check_eq("rst_addr", 32'(pix_addr), 32'd0);
    reset = 1'b1;
    tick();

    // 1: ramp image, all-ones kernel, window 0
    run_window("w0", 2'd0, 12'd45, 1'b1, addr_w0);
    check_eq("hold_addr", 32'(pix_addr), 32'd0);
    accept();

    // 2: window 3
    run_window("w3", 2'd3, 12'd90, 1'b1, addr_w3);
    accept();

    // 3: center-only kernel, window 2 selects pixel 9
    kernel = K_CENTER;
    run_window("ctr", 2'd2, 12'd9, 1'b0, no_addr);
    accept();

    // 4: all 15 with all -1 coefficients
    for (int i = 0; i < 16; i++) img[i] = 4'hF;
    kernel = K_NEG;
`ifdef CONV_RELU_EN
    exp_neg = 12'h000;
`else
    exp_neg = 12'hF79;
`endif
    run_window("neg", 2'd1, exp_neg, 1'b0, no_addr);

    // 5: hold with ready low 5 cycles, start pulses ignored
    for (int i = 0; i < 5; i++) begin
      start = (i % 2 == 0);
      tick();
      check_eq($sformatf("hold%0d_valid", i), 32'(result_valid), 32'd1);
      check_eq($sformatf("hold%0d_result", i), 32'(result), 32'(exp_neg));
    end
    start = 1'b0;
    accept();
    tick();
    check_eq("idle_after_accept", 32'(busy), 32'd0);
    check_eq("result_kept", 32'(result), 32'(exp_neg));

    // 6: reset during tap 4, then a clean run on window 1 (sum 54)
    load_ramp();
    kernel = K_ONES;
    win_idx = 2'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check_eq("abort_addr_tap4", 32'(pix_addr), 32'd10);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_valid", 32'(result_valid), 32'd0);
    check_eq("abort_result", 32'(result), 32'd0);
    check_eq("abort_addr", 32'(pix_addr), 32'd0);
    tick();
    run_window("w1", 2'd1, 12'd54, 1'b0, no_addr);
    accept();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
